// File: rtl/instr_sequencer.sv
// instr_sequencer
//   Multi-cycle control sequencer for a small accumulator machine. It fetches
//   9-bit instructions from a combinational ROM and drives the opcode, operand
//   and strobes for the ALU, accumulator and data memory. It also resolves
//   PC-relative branches against a two-bit flag register.
//
// Ports
//   clk      : system clock, rising edge active
//   reset_n  : asynchronous active-low reset
//   start    : level, starts a program run from IDLE or DONE
//   last_pc  : address of the final instruction of the program
//   instr    : ROM data at address pc ([8:5] opcode, [4:0] operand)
//   alu_z    : ALU zero flag for the op currently presented
//   alu_neg  : ALU negative flag for the op currently presented
//   pc       : instruction ROM address
//   op       : opcode to the ALU (held outside EXEC)
//   operand  : zero-extended 5-bit operand (held outside EXEC)
//   acc_we   : accumulator write strobe
//   mem_re   : data-memory read strobe
//   mem_we   : data-memory write strobe
//   done     : program finished, waiting for start
module instr_sequencer (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [9:0] last_pc,
  input  logic [8:0] instr,
  input  logic       alu_z,
  input  logic       alu_neg,
  output logic [9:0] pc,
  output logic [3:0] op,
  output logic [7:0] operand,
  output logic       acc_we,
  output logic       mem_re,
  output logic       mem_we,
  output logic       done
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StFetch   = 3'd1;
  localparam logic [2:0] StExec    = 3'd2;
  localparam logic [2:0] StMemWait = 3'd3;
  localparam logic [2:0] StDone    = 3'd4;

  localparam logic [3:0] kADD = 4'd0;
  localparam logic [3:0] kSUB = 4'd1;
  localparam logic [3:0] kAND = 4'd2;
  localparam logic [3:0] kXOR = 4'd3;
  localparam logic [3:0] kLDI = 4'd4;
  localparam logic [3:0] kSHL = 4'd5;
  localparam logic [3:0] kSHR = 4'd6;
  localparam logic [3:0] kLDR = 4'd7;
  localparam logic [3:0] kSTR = 4'd8;
  localparam logic [3:0] kMLD = 4'd9;
  localparam logic [3:0] kMST = 4'd10;
  localparam logic [3:0] kJMP = 4'd11;
  localparam logic [3:0] kBRN = 4'd12;
  localparam logic [3:0] kBRZ = 4'd13;
  localparam logic [3:0] kNOT = 4'd14;
  localparam logic [3:0] kCLR = 4'd15;

  logic [2:0] state_q, state_d;
  logic [9:0] pc_q, pc_d;
  logic [8:0] ir_q, ir_d;
  logic       zf_q, zf_d;
  logic       nf_q, nf_d;

  logic [3:0] irOpcode;
  logic       writesAcc;
  logic       writesMem;
  logic       readsMem;
  logic       keepsFlags;
  logic       branchTaken;
  logic [9:0] branchTarget;
  logic [9:0] pcNext;
  logic       atLast;

  // Decode of the latched instruction. The IR only changes at the end of
  // FETCH, so op/operand naturally hold their last values in every other state.
  always_comb begin
    irOpcode     = ir_q[8:5];
    writesAcc    = 1'b0;
    writesMem    = 1'b0;
    readsMem     = 1'b0;
    keepsFlags   = 1'b0;
    branchTaken  = 1'b0;
    case (irOpcode)
      kADD, kSUB, kAND, kXOR, kLDI, kSHL, kSHR, kNOT, kCLR: writesAcc = 1'b1;
      kSTR:    writesMem = 1'b1;
      kMST: begin
        writesMem  = 1'b1;
        keepsFlags = 1'b1;
      end
      kLDR, kMLD: readsMem = 1'b1;
      kJMP: begin
        branchTaken = 1'b1;
        keepsFlags  = 1'b1;
      end
      kBRN: begin
        branchTaken = nf_q;
        keepsFlags  = 1'b1;
      end
      kBRZ: begin
        branchTaken = zf_q;
        keepsFlags  = 1'b1;
      end
      default: ;
    endcase
    // 10-bit add wraps modulo 1024 for both the offset and the increment.
    branchTarget = pc_q + {{5{ir_q[4]}}, ir_q[4:0]};
    pcNext       = branchTaken ? branchTarget : (pc_q + 10'd1);
    atLast       = (pc_q == last_pc);
  end

  // Next-state and strobe logic. Strobes are a pure function of the current
  // state so an asynchronous reset clears them the moment state_q drops to IDLE.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    zf_d    = zf_q;
    nf_d    = nf_q;
    acc_we  = 1'b0;
    mem_re  = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StFetch;
          pc_d    = 10'd0;
        end
      end
      StFetch: begin
        ir_d    = instr;
        state_d = StExec;
      end
      StExec: begin
        acc_we = writesAcc;
        mem_we = writesMem;
        mem_re = readsMem;
        if (!keepsFlags) begin
          zf_d = alu_z;
          nf_d = alu_neg;
        end
        if (readsMem) begin
          state_d = StMemWait;
        end else if (atLast) begin
          // Completion wins over any branch: pc stays on last_pc.
          state_d = StDone;
        end else begin
          state_d = StFetch;
          pc_d    = pcNext;
        end
      end
      StMemWait: begin
        acc_we = 1'b1;
        mem_re = 1'b1;
        zf_d   = alu_z;
        nf_d   = alu_neg;
        if (atLast) begin
          state_d = StDone;
        end else begin
          state_d = StFetch;
          pc_d    = pc_q + 10'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      pc_q    <= 10'd0;
      ir_q    <= 9'd0;
      zf_q    <= 1'b0;
      nf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      zf_q    <= zf_d;
      nf_q    <= nf_d;
    end
  end

  assign pc      = pc_q;
  assign op      = ir_q[8:5];
  assign operand = {3'b000, ir_q[4:0]};
  assign done    = (state_q == StDone);

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; both ports are listed first below.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  level; begins a program run from IDLE or DONE.
REQ-005 last_pc  input  10  address of the final instruction of the program.
REQ-006 instr  input  9  instruction ROM data at address pc, combinational; [8:5] opcode, [4:0] operand.
REQ-007 alu_z  input  1  zero flag returned by the ALU for the current op.
REQ-008 alu_neg  input  1  negative flag returned by the ALU for the current op.
REQ-009 pc  output  10  instruction ROM address.
REQ-010 op  output  4  opcode to the ALU, definitions-package encoding (kADD=0 ... kBRZ=13, kNOT=14, kCLR=15).
REQ-011 operand  output  8  zero-extended instr[4:0] of the latched instruction.
REQ-012 acc_we  output  1  one-cycle accumulator write strobe.
REQ-013 mem_re  output  1  data-memory read strobe.
REQ-014 mem_we  output  1  data-memory write strobe.
REQ-015 done  output  1  program finished.

Function
REQ-016 The FSM SHALL have the states IDLE, FETCH, EXEC, MEMWAIT and DONE.
REQ-017 IDLE SHALL go to FETCH when start=1 and SHALL set pc to 0.
REQ-018 FETCH SHALL latch instr into an internal instruction register (IR) and go to EXEC next cycle.
REQ-019 In EXEC, op and operand SHALL be driven from the IR; op and operand SHALL hold their last values in all other states.
REQ-020 In EXEC, the block SHALL register alu_z and alu_neg into the flag register z_f and n_f, except for kJMP, kBRN, kBRZ and kMST, which leave the flags unchanged.
REQ-021 EXEC acc_we SHALL be 1 for kADD, kSUB, kAND, kXOR, kLDI, kSHL, kSHR, kNOT and kCLR.
REQ-022 EXEC mem_we SHALL be 1 for kSTR and kMST.
REQ-023 EXEC mem_re SHALL be 1 for kLDR and kMLD, and the FSM SHALL then go to MEMWAIT.
REQ-024 MEMWAIT SHALL hold mem_re=1, assert acc_we=1 for exactly one cycle, register the ALU flags, then advance pc.
REQ-025 Branch target SHALL be pc + sign-extended IR[4:0] (range -16..+15), computed modulo 1024.
REQ-026 kJMP SHALL always branch.
REQ-027 kBRN SHALL branch if n_f=1, using the flag value registered before this instruction.
REQ-028 kBRZ SHALL branch if z_f=1, using the flag value registered before this instruction.
REQ-029 A non-taken branch and every non-branch instruction SHALL set pc to pc+1, modulo 1024 (0x3FF wraps to 0x000).
REQ-030 A branch with offset 0 SHALL re-execute the same address; this is legal, with no deadlock detection.
REQ-031 On completion of the instruction at pc==last_pc, the FSM SHALL go to DONE instead of FETCH, and pc SHALL hold.
REQ-032 A taken branch out of last_pc SHALL still go to DONE.
REQ-033 DONE SHALL assert done=1 and remain until start=1, then clear done, set pc=0 and go to FETCH.
REQ-034 start SHALL be ignored in FETCH, EXEC and MEMWAIT.
REQ-035 Timing SHALL be 2 cycles per instruction, or 3 for kLDR/kMLD.
REQ-036 acc_we, mem_re and mem_we SHALL be 0 in IDLE, FETCH and DONE.
REQ-037 mem_we and mem_re SHALL never both be 1 in the same cycle.

Reset
REQ-038 reset_n=0 SHALL immediately, without waiting for clk, force: state IDLE, pc=0, IR=0, op=0, operand=0, z_f=0, n_f=0, acc_we=0, mem_re=0, mem_we=0, done=0.
REQ-039 Reset asserted in any state, including MEMWAIT, SHALL abort the instruction with no further strobes.
REQ-040 Operation SHALL resume only via start after reset_n returns to 1.

Verification
REQ-041 Straight-line: ROM = kLDI 5, kADD 3, kMST 2; last_pc=2; start -> acc_we in cycles 2 and 4, mem_we in cycle 6, done in cycle 7, pc=2.
REQ-042 Load timing: kMLD 4 at pc 0 -> mem_re high for 2 cycles, acc_we only in MEMWAIT, next FETCH at pc=1 on cycle 4.
REQ-043 Conditional branch: kSUB with alu_z=1, then kBRZ offset -2 (5'b11110) at pc 5 -> pc=3; same with alu_z=0 -> pc=6; kBRN with n_f=0 -> not taken.
REQ-044 Wrap: kJMP +15 at pc=0x3FA -> pc=0x009; non-branch at pc=0x3FF -> pc=0x000.
REQ-045 Async reset pulsed mid-MEMWAIT, between clock edges -> all outputs 0 at once, state IDLE; start -> FETCH with pc=0.
REQ-046 Restart: in DONE, hold start=0 for 10 cycles -> done stays 1; pulse start -> done=0 and pc=0 next cycle.
